// File: rtl/iram_loader.sv
// Loadable instruction memory for the fetch stage: a load session writes words at an
// auto-incrementing pointer, and fetches past the loaded length return NOP_WORD with addr_err.
module iram_loader #(
  parameter int unsigned        INSTR_W  = 20,
  parameter int unsigned        ADDR_W   = 7,
  parameter int unsigned        DEPTH    = 50,
  parameter logic [INSTR_W-1:0] NOP_WORD = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_en,
  input  logic               load_we,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               fetch_req,
  input  logic [ADDR_W-1:0]  PC,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  output logic               addr_err,
  output logic               busy,
  output logic [ADDR_W-1:0]  load_cnt,
  output logic               load_ovf
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so the pointer can hold DEPTH even when DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] PtrOne = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W:0]    ptr_q, ptr_d;
  logic [ADDR_W:0]    prog_len_q, prog_len_d;
  logic               ovf_q, ovf_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;

  logic               mem_we;
  logic [IdxW-1:0]    wr_idx;
  logic [IdxW-1:0]    rd_idx;
  logic               in_range;

  logic [INSTR_W-1:0] mem [DEPTH];

  // prog_len never exceeds DEPTH, so an in-range PC always indexes inside the array.
  assign in_range = ({1'b0, PC} < prog_len_q);
  assign rd_idx   = PC[IdxW-1:0];

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    prog_len_d = prog_len_q;
    ovf_d      = ovf_q;
    instr_d    = instr_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    mem_we     = 1'b0;
    wr_idx     = ptr_q[IdxW-1:0];

    unique case (state_q)
      // IDLE behaves like RUN with prog_len == 0, so fetches there report errors.
      StIdle, StRun: begin
        if (load_en) begin
          state_d = StLoad;
          ptr_d   = '0;
          ovf_d   = 1'b0;
          if (load_we) begin
            mem_we = 1'b1;
            wr_idx = '0;
            ptr_d  = PtrOne;
          end
        end else if (fetch_req) begin
          valid_d = 1'b1;
          if (in_range) begin
            instr_d = mem[rd_idx];
          end else begin
            instr_d = NOP_WORD;
            err_d   = 1'b1;
          end
        end
      end

      StLoad: begin
        if (!load_en) begin
          state_d    = StRun;
          prog_len_d = ptr_q;
        end else if (load_we) begin
          if (ptr_q < DepthW) begin
            mem_we = 1'b1;
            ptr_d  = ptr_q + PtrOne;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      prog_len_q <= '0;
      ovf_q      <= 1'b0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      prog_len_q <= prog_len_d;
      ovf_q      <= ovf_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  // Array contents survive reset; only the write itself is suppressed on a reset edge.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem[wr_idx] <= load_data;
    end
  end

  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign addr_err    = err_q;
  assign busy        = (state_q == StLoad);
  assign load_cnt    = ptr_q[ADDR_W-1:0];
  assign load_ovf    = ovf_q;

endmodule
